rv32_decode_stage: RTL
======================

// Module: rv32_decode_stage
// PURPOSE
//  Second pipeline stage: consumes the fetch buffer, decodes RV32I, reads the register file, bypasses operands
//  from EX/MEM/WB, detects load-use hazards and registers the result into the decode buffer for execute.
//  Stalls PC/fetch on hazards; flushed by the same set_nop/set_nop_pc redirect that drives fetch.
// PARAMETERS
//  BYPASS_EN  1             1: EX/MEM/WB operand bypass; 0: any RAW match on a valid writer stalls
//  NOP_INSTR  32'h0000_0013 instruction word placed in every bubble (addi x0,x0,0)
// PORTS
//  clk         in   1   core clock, rising edge
//  resetn      in   1   synchronous active-low reset
//  set_nop     in   1   flush: next decode buffer entry is a bubble
//  set_nop_pc  in   32  pc recorded in the flush bubble
//  stall_in    in   1   execute cannot accept; hold decode buffer
//  fetch_data  in   fetch_buffer_data_t  {pc, instr} from fetch stage register
//  stall       out  1   hold PC and fetch (hazard or stall_in)
//  rs1_addr    out  5   regfile read index = instr[19:15]
//  rs2_addr    out  5   regfile read index = instr[24:20]
//  rs1_rdata   in   32  regfile combinational read data
//  rs2_rdata   in   32  regfile combinational read data
//  ex_rd/ex_wb_en/ex_is_load/ex_result     in  5/1/1/32  EX writer
//  mem_rd/mem_wb_en/mem_result             in  5/1/32    MEM writer
//  wb_rd/wb_wb_en/wb_result                in  5/1/32    WB writer (regfile write same cycle)
//  dec_pc      out  32  registered pc
//  dec_instr   out  32  registered instruction word
//  dec_rd      out  5   dest index (0 for S/B/FENCE/illegal)
//  dec_fmt     out  3   0 R,1 I,2 S,3 B,4 U,5 J,6 SYS,7 NONE
//  dec_imm     out  32  sign-extended immediate per format, 0 for R/NONE
//  dec_rs1_val out  32  bypassed rs1 operand
//  dec_rs2_val out  32  bypassed rs2 operand
//  dec_illegal out  1   opcode not in RV32I base set
// BEHAVIOUR
//  - All dec_* outputs are registers; latency 1 cycle from fetch_data to dec_*.
//  - Reset (resetn=0 at edge): dec_pc=0, dec_instr=NOP_INSTR, dec_rd=0, dec_fmt=1, dec_imm=0, vals=0,
//    dec_illegal=0. stall is combinational and is 0 while resetn=0.
//  - Format from opcode[6:0]: 0110011 R; 0010011/0000011/1100111 I; 0100011 S; 1100011 B;
//    0110111/0010111 U; 1101111 J; 1110011 SYS (I-imm); 0001111 I (FENCE, rd forced 0); else NONE + illegal.
//  - Imm: I {20{i[31]},i[31:20]}; S {..,i[31:25],i[11:7]}; B {..,i[7],i[30:25],i[11:8],0};
//    U {i[31:12],12'b0}; J {..,i[19:12],i[20],i[30:21],0}. Illegal entries carry dec_fmt=7, dec_imm=0.
//  - Operand select per source (skip if index 0 -> value 0): EX match&&!ex_is_load -> ex_result;
//    else MEM match -> mem_result; else WB match -> wb_result; else regfile. Match = wb_en && rd==rs && rd!=0.
//  - Source use: rs1 for R/I/S/B/SYS; rs2 for R/S/B. Unused sources never cause hazards.
//  - hazard = used source matches EX with ex_is_load (BYPASS_EN=1), or matches any writer stage (BYPASS_EN=0).
//  - stall = hazard | stall_in.
//  - Register update priority at each edge:
//    1. !resetn -> reset values.
//    2. set_nop -> bubble: pc=set_nop_pc, instr=NOP_INSTR, rd=0, fmt=1, imm=0, vals=0, illegal=0.
//       Flush wins over stall_in and hazard.
//    3. stall_in -> hold all dec_* unchanged.
//    4. hazard -> bubble with pc=fetch_data.pc; fetch_data re-presented next cycle because PC held.
//    5. else capture decoded fetch_data.
//  - Bubbles (NOP from fetch or injected) never assert hazard and write rd=0.
//  - Reset mid-stall: reset wins; first post-reset cycle decodes whatever fetch presents.
// TESTING
//  - Reset: hold resetn=0 3 cycles -> dec_instr=0x00000013, dec_pc=0, stall=0.
//  - addi x1,x0,-1 (0xFFF00093) pc=0x40 -> next cycle: fmt=1, rd=1, imm=0xFFFFFFFF, rs1_val=0, illegal=0.
//  - add x3,x1,x2 with ex_rd=1,ex_wb_en=1,ex_result=5, mem_rd=2,mem_result=7, regfile=9/9 -> rs1_val=5, rs2_val=7.
//  - Load-use: ex_rd=1,ex_is_load=1, decode add x3,x1,x2 -> stall=1, bubble at pc; ex_is_load=0 next -> add passes.
//  - Flush plus stall_in simultaneously, set_nop_pc=0x100 -> dec_pc=0x100, dec_instr=NOP.
//  - beq x1,x2,-4 (0xFE208EE3) -> fmt=3, rd=0, imm=0xFFFFFFFC; opcode 0x7F word -> illegal=1, fmt=7.

Source files
------------

// File: rtl/rv32_decode_stage.sv
// ---------------------------------------------------------------------------
// rv32_decode_stage
//   Second pipeline stage of the RV32I core. Takes the {pc, instr} word held
//   in the fetch buffer and decodes it. It reads both register-file ports,
//   bypasses operands from the EX/MEM/WB writers, and detects load-use hazards.
//   The result is registered into the decode buffer that feeds execute.
//   On a hazard it holds PC/fetch and injects a bubble. A set_nop redirect
//   flushes the decode buffer in the same cycle that it redirects fetch.
//
// Parameters
//   BYPASS_EN  1: operand bypass from EX/MEM/WB; 0: any RAW match stalls
//   NOP_INSTR  instruction word placed in every bubble (addi x0,x0,0)
//
// Ports
//   clk, resetn        core clock / synchronous active-low reset
//   set_nop,set_nop_pc flush request and the pc recorded in the flush bubble
//   stall_in           execute cannot accept; decode buffer holds
//   fetch_data[63:0]   {pc[63:32], instr[31:0]} from the fetch stage register
//   stall              hold PC and fetch (hazard or stall_in), 0 in reset
//   rs1/rs2_addr       register-file read indices
//   rs1/rs2_rdata      register-file combinational read data
//   ex_*/mem_*/wb_*    destination, write enable and result of each writer
//   dec_*              registered decode results for execute
// ---------------------------------------------------------------------------
module rv32_decode_stage #(
  parameter bit          BYPASS_EN = 1'b1,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        set_nop,
  input  logic [31:0] set_nop_pc,
  input  logic        stall_in,
  input  logic [63:0] fetch_data,
  output logic        stall,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_rdata,
  input  logic [31:0] rs2_rdata,
  input  logic [4:0]  ex_rd,
  input  logic        ex_wb_en,
  input  logic        ex_is_load,
  input  logic [31:0] ex_result,
  input  logic [4:0]  mem_rd,
  input  logic        mem_wb_en,
  input  logic [31:0] mem_result,
  input  logic [4:0]  wb_rd,
  input  logic        wb_wb_en,
  input  logic [31:0] wb_result,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr,
  output logic [4:0]  dec_rd,
  output logic [2:0]  dec_fmt,
  output logic [31:0] dec_imm,
  output logic [31:0] dec_rs1_val,
  output logic [31:0] dec_rs2_val,
  output logic        dec_illegal
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_SYS  = 3'd6;
  localparam logic [2:0] FMT_NONE = 3'd7;

  logic [31:0] fd_pc;
  logic [31:0] fd_instr;
  logic [6:0]  opcode;

  assign fd_pc    = fetch_data[63:32];
  assign fd_instr = fetch_data[31:0];
  assign opcode   = fd_instr[6:0];
  assign rs1_addr = fd_instr[19:15];
  assign rs2_addr = fd_instr[24:20];

  // Immediate candidates for every format
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{fd_instr[31]}}, fd_instr[31:20]};
  assign imm_s = {{20{fd_instr[31]}}, fd_instr[31:25], fd_instr[11:7]};
  assign imm_b = {{19{fd_instr[31]}}, fd_instr[31], fd_instr[7], fd_instr[30:25],
                  fd_instr[11:8], 1'b0};
  assign imm_u = {fd_instr[31:12], 12'b0};
  assign imm_j = {{11{fd_instr[31]}}, fd_instr[31], fd_instr[19:12], fd_instr[20],
                  fd_instr[30:21], 1'b0};

  // Opcode decode: format, destination, immediate and source usage.
  // FENCE decodes as I-format, but it never writes a register.
  logic [2:0]  fmt;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        illegal;
  logic        use_rs1;
  logic        use_rs2;

  always_comb begin
    fmt     = FMT_NONE;
    rd      = 5'd0;
    imm     = 32'd0;
    illegal = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      7'b0110011: begin
        fmt = FMT_R; rd = fd_instr[11:7]; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        fmt = FMT_I; rd = fd_instr[11:7]; imm = imm_i; use_rs1 = 1'b1;
      end
      7'b0001111: begin
        fmt = FMT_I; imm = imm_i; use_rs1 = 1'b1;
      end
      7'b0100011: begin
        fmt = FMT_S; imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b1100011: begin
        fmt = FMT_B; imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        fmt = FMT_U; rd = fd_instr[11:7]; imm = imm_u;
      end
      7'b1101111: begin
        fmt = FMT_J; rd = fd_instr[11:7]; imm = imm_j;
      end
      7'b1110011: begin
        fmt = FMT_SYS; rd = fd_instr[11:7]; imm = imm_i; use_rs1 = 1'b1;
      end
      default: begin
        fmt = FMT_NONE; illegal = 1'b1;
      end
    endcase
  end

  // Writer matches. x0 is never a real destination, so it never matches.
  logic ex_hit1, mem_hit1, wb_hit1, ex_hit2, mem_hit2, wb_hit2;
  assign ex_hit1  = ex_wb_en  && (ex_rd  == rs1_addr) && (rs1_addr != 5'd0);
  assign mem_hit1 = mem_wb_en && (mem_rd == rs1_addr) && (rs1_addr != 5'd0);
  assign wb_hit1  = wb_wb_en  && (wb_rd  == rs1_addr) && (rs1_addr != 5'd0);
  assign ex_hit2  = ex_wb_en  && (ex_rd  == rs2_addr) && (rs2_addr != 5'd0);
  assign mem_hit2 = mem_wb_en && (mem_rd == rs2_addr) && (rs2_addr != 5'd0);
  assign wb_hit2  = wb_wb_en  && (wb_rd  == rs2_addr) && (rs2_addr != 5'd0);

  // Operand select, youngest writer first. A load in EX has no data yet, so
  // it is skipped here; the hazard logic turns that case into a bubble.
  // WB is bypassed because the regfile write lands in the same cycle.
  logic [31:0] rs1_val, rs2_val;

  always_comb begin
    rs1_val = rs1_rdata;
    if (rs1_addr == 5'd0)                    rs1_val = 32'd0;
    else if (BYPASS_EN && ex_hit1 && !ex_is_load) rs1_val = ex_result;
    else if (BYPASS_EN && mem_hit1)          rs1_val = mem_result;
    else if (BYPASS_EN && wb_hit1)           rs1_val = wb_result;
  end

  always_comb begin
    rs2_val = rs2_rdata;
    if (rs2_addr == 5'd0)                    rs2_val = 32'd0;
    else if (BYPASS_EN && ex_hit2 && !ex_is_load) rs2_val = ex_result;
    else if (BYPASS_EN && mem_hit2)          rs2_val = mem_result;
    else if (BYPASS_EN && wb_hit2)           rs2_val = wb_result;
  end

  // Hazard only counts for sources the format actually reads. Without
  // bypass, every RAW match has to wait until the regfile holds the value.
  logic hazard;
  always_comb begin
    if (BYPASS_EN) begin
      hazard = (use_rs1 && ex_hit1 && ex_is_load) ||
               (use_rs2 && ex_hit2 && ex_is_load);
    end else begin
      hazard = (use_rs1 && (ex_hit1 || mem_hit1 || wb_hit1)) ||
               (use_rs2 && (ex_hit2 || mem_hit2 || wb_hit2));
    end
  end

  assign stall = resetn && (hazard || stall_in);

  // Decode buffer registers
  logic [31:0] dec_pc_q, dec_pc_d;
  logic [31:0] dec_instr_q, dec_instr_d;
  logic [4:0]  dec_rd_q, dec_rd_d;
  logic [2:0]  dec_fmt_q, dec_fmt_d;
  logic [31:0] dec_imm_q, dec_imm_d;
  logic [31:0] dec_rs1_val_q, dec_rs1_val_d;
  logic [31:0] dec_rs2_val_q, dec_rs2_val_d;
  logic        dec_illegal_q, dec_illegal_d;

  // Update priority: flush, then hold for stall_in, then a hazard bubble at
  // the stalled pc, then capture the decoded fetch word.
  always_comb begin
    dec_pc_d      = dec_pc_q;
    dec_instr_d   = dec_instr_q;
    dec_rd_d      = dec_rd_q;
    dec_fmt_d     = dec_fmt_q;
    dec_imm_d     = dec_imm_q;
    dec_rs1_val_d = dec_rs1_val_q;
    dec_rs2_val_d = dec_rs2_val_q;
    dec_illegal_d = dec_illegal_q;
    if (set_nop || (!stall_in && hazard)) begin
      dec_pc_d      = set_nop ? set_nop_pc : fd_pc;
      dec_instr_d   = NOP_INSTR;
      dec_rd_d      = 5'd0;
      dec_fmt_d     = FMT_I;
      dec_imm_d     = 32'd0;
      dec_rs1_val_d = 32'd0;
      dec_rs2_val_d = 32'd0;
      dec_illegal_d = 1'b0;
    end else if (!stall_in) begin
      dec_pc_d      = fd_pc;
      dec_instr_d   = fd_instr;
      dec_rd_d      = rd;
      dec_fmt_d     = fmt;
      dec_imm_d     = imm;
      dec_rs1_val_d = rs1_val;
      dec_rs2_val_d = rs2_val;
      dec_illegal_d = illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dec_pc_q      <= 32'd0;
      dec_instr_q   <= NOP_INSTR;
      dec_rd_q      <= 5'd0;
      dec_fmt_q     <= FMT_I;
      dec_imm_q     <= 32'd0;
      dec_rs1_val_q <= 32'd0;
      dec_rs2_val_q <= 32'd0;
      dec_illegal_q <= 1'b0;
    end else begin
      dec_pc_q      <= dec_pc_d;
      dec_instr_q   <= dec_instr_d;
      dec_rd_q      <= dec_rd_d;
      dec_fmt_q     <= dec_fmt_d;
      dec_imm_q     <= dec_imm_d;
      dec_rs1_val_q <= dec_rs1_val_d;
      dec_rs2_val_q <= dec_rs2_val_d;
      dec_illegal_q <= dec_illegal_d;
    end
  end

  assign dec_pc      = dec_pc_q;
  assign dec_instr   = dec_instr_q;
  assign dec_rd      = dec_rd_q;
  assign dec_fmt     = dec_fmt_q;
  assign dec_imm     = dec_imm_q;
  assign dec_rs1_val = dec_rs1_val_q;
  assign dec_rs2_val = dec_rs2_val_q;
  assign dec_illegal = dec_illegal_q;

endmodule
